sc_updown_modcounter: RTL and testbench

//   Parametrised up/down modulo counter; next generation of the SC up-speed counter.

---
 rtl/sc_updown_modcounter_pkg.sv | 17 +
 rtl/sc_updown_modcounter_if.sv | 40 ++++
 rtl/sc_updown_modcounter_prescaler.sv | 45 ++++
 rtl/sc_updown_modcounter.sv | 94 +++++++++
 tb/tb_sc_updown_modcounter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/sc_updown_modcounter_pkg.sv
// Shared definitions for the SC counter family: direction encoding and a
// parameter sanity helper used at elaboration time.
package sc_counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // True when the terminal value fits the register and the prescaler is usable.
    function automatic bit params_ok(input int datawidth, input int max_value,
                                     input int prescale);
        bit ok;
        ok = (datawidth >= 1) && (datawidth <= 31) && (max_value >= 0) &&
             (max_value < (1 << datawidth)) && (prescale >= 1);
        return ok;
    endfunction

endpackage

// File: rtl/sc_updown_modcounter_if.sv
// Control and status bundle of the up/down modulo counter. The counter side
// uses the slave modport, the controlling block uses the master modport.
interface sc_updown_modcounter_if #(
    parameter int DATAWIDTH = 8
);
    logic                 SC_UPDOWNCOUNTER_enable_InLow;
    logic                 SC_UPDOWNCOUNTER_down_InHigh;
    logic                 SC_UPDOWNCOUNTER_clear_InHigh;
    logic                 SC_UPDOWNCOUNTER_load_InHigh;
    logic [DATAWIDTH-1:0] SC_UPDOWNCOUNTER_load_InBUS;
    logic [DATAWIDTH-1:0] SC_UPDOWNCOUNTER_data_OutBUS;
    logic                 SC_UPDOWNCOUNTER_wrap_OutHigh;
    logic                 SC_UPDOWNCOUNTER_zero_OutHigh;
    logic                 SC_UPDOWNCOUNTER_max_OutHigh;

    modport master (
        output SC_UPDOWNCOUNTER_enable_InLow,
        output SC_UPDOWNCOUNTER_down_InHigh,
        output SC_UPDOWNCOUNTER_clear_InHigh,
        output SC_UPDOWNCOUNTER_load_InHigh,
        output SC_UPDOWNCOUNTER_load_InBUS,
        input  SC_UPDOWNCOUNTER_data_OutBUS,
        input  SC_UPDOWNCOUNTER_wrap_OutHigh,
        input  SC_UPDOWNCOUNTER_zero_OutHigh,
        input  SC_UPDOWNCOUNTER_max_OutHigh
    );

    modport slave (
        input  SC_UPDOWNCOUNTER_enable_InLow,
        input  SC_UPDOWNCOUNTER_down_InHigh,
        input  SC_UPDOWNCOUNTER_clear_InHigh,
        input  SC_UPDOWNCOUNTER_load_InHigh,
        input  SC_UPDOWNCOUNTER_load_InBUS,
        output SC_UPDOWNCOUNTER_data_OutBUS,
        output SC_UPDOWNCOUNTER_wrap_OutHigh,
        output SC_UPDOWNCOUNTER_zero_OutHigh,
        output SC_UPDOWNCOUNTER_max_OutHigh
    );

endinterface

// File: rtl/sc_updown_modcounter_prescaler.sv
// Clock-enable prescaler: emits one tick every PRESCALE enabled clocks.
// A frozen (disabled) clock keeps the phase; restart forces the phase to 0.
// With PRESCALE=1 the phase register is constant 0 and tick equals enable.
module sc_tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    assign tick = enable && (phase_q == LAST_PHASE);

    // Next phase: restart dominates, otherwise advance modulo PRESCALE while enabled.
    always_comb begin
        phase_d = phase_q;
        if (restart) begin
            phase_d = '0;
        end else if (enable) begin
            if (tick) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/sc_updown_modcounter.sv
// Up/down modulo counter with clear, clamped parallel load, prescaled
// counting and a registered one-cycle wrap pulse.
module sc_updown_modcounter
    import sc_counter_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int MAX_VALUE = 255,
    parameter int PRESCALE  = 1
) (
    input  logic                  SC_UPDOWNCOUNTER_CLOCK_50,
    input  logic                  SC_UPDOWNCOUNTER_RESET_InLow,
    sc_updown_modcounter_if.slave cnt_if
);

    generate
        if (!params_ok(DATAWIDTH, MAX_VALUE, PRESCALE)) begin : g_bad_params
            $error("sc_updown_modcounter: illegal DATAWIDTH/MAX_VALUE/PRESCALE");
        end
    endgenerate

    localparam logic [DATAWIDTH-1:0] MAX_V = DATAWIDTH'(MAX_VALUE);

    logic [DATAWIDTH-1:0] count_q;
    logic [DATAWIDTH-1:0] count_d;
    logic                 wrap_q;
    logic                 wrap_d;
    logic                 tick;
    logic                 restart;

    logic                 clear;
    logic                 load;
    logic [DATAWIDTH-1:0] load_val;

    assign clear    = cnt_if.SC_UPDOWNCOUNTER_clear_InHigh;
    assign load     = cnt_if.SC_UPDOWNCOUNTER_load_InHigh;
    assign load_val = cnt_if.SC_UPDOWNCOUNTER_load_InBUS;

    // Clear and load both restart the prescaler so a fresh count period follows.
    assign restart = clear | load;

    sc_tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (SC_UPDOWNCOUNTER_CLOCK_50),
        .rst_n   (SC_UPDOWNCOUNTER_RESET_InLow),
        .enable  (!cnt_if.SC_UPDOWNCOUNTER_enable_InLow),
        .restart (restart),
        .tick    (tick)
    );

    // Next count/wrap with priority clear > load > step > hold; wrap only on a boundary step.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (tick) begin
            if (cnt_if.SC_UPDOWNCOUNTER_down_InHigh == DIR_DOWN) begin
                if (count_q == '0) begin
                    count_d = MAX_V;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - DATAWIDTH'(1);
                end
            end else begin
                if (count_q >= MAX_V) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + DATAWIDTH'(1);
                end
            end
        end
    end

    // Count and wrap state register.
    always_ff @(posedge SC_UPDOWNCOUNTER_CLOCK_50 or negedge SC_UPDOWNCOUNTER_RESET_InLow) begin
        if (!SC_UPDOWNCOUNTER_RESET_InLow) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cnt_if.SC_UPDOWNCOUNTER_data_OutBUS  = count_q;
    assign cnt_if.SC_UPDOWNCOUNTER_wrap_OutHigh = wrap_q;
    assign cnt_if.SC_UPDOWNCOUNTER_zero_OutHigh = (count_q == '0);
    assign cnt_if.SC_UPDOWNCOUNTER_max_OutHigh  = (count_q == MAX_V);

endmodule

// File: tb/tb_sc_updown_modcounter.sv
// Bench for sc_updown_modcounter: two instances (MAX 9 / PRESCALE 1 and
// MAX 150 / PRESCALE 4) share stimulus and are compared every cycle against
// a modular-arithmetic reference model, with directed scenarios first and
// randomized traffic (including async resets) afterwards.
module tb_sc_updown_modcounter;
    import sc_counter_pkg::*;

    localparam int DW = 8;
    localparam int MAXV [2] = '{9, 150};
    localparam int PRE  [2] = '{1, 4};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_n, dn, clr, ld;
    logic [DW-1:0] ldv;

    int m_cnt [2];
    int m_ph  [2];
    int m_wr  [2];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    sc_updown_modcounter_if #(.DATAWIDTH(DW)) if_a ();
    sc_updown_modcounter_if #(.DATAWIDTH(DW)) if_b ();

    assign if_a.SC_UPDOWNCOUNTER_enable_InLow = en_n;
    assign if_a.SC_UPDOWNCOUNTER_down_InHigh  = dn;
    assign if_a.SC_UPDOWNCOUNTER_clear_InHigh = clr;
    assign if_a.SC_UPDOWNCOUNTER_load_InHigh  = ld;
    assign if_a.SC_UPDOWNCOUNTER_load_InBUS   = ldv;
    assign if_b.SC_UPDOWNCOUNTER_enable_InLow = en_n;
    assign if_b.SC_UPDOWNCOUNTER_down_InHigh  = dn;
    assign if_b.SC_UPDOWNCOUNTER_clear_InHigh = clr;
    assign if_b.SC_UPDOWNCOUNTER_load_InHigh  = ld;
    assign if_b.SC_UPDOWNCOUNTER_load_InBUS   = ldv;

    sc_updown_modcounter #(.DATAWIDTH(DW), .MAX_VALUE(9), .PRESCALE(1)) u_a (
        .SC_UPDOWNCOUNTER_CLOCK_50    (clk),
        .SC_UPDOWNCOUNTER_RESET_InLow (rst_n),
        .cnt_if                       (if_a)
    );

    sc_updown_modcounter #(.DATAWIDTH(DW), .MAX_VALUE(150), .PRESCALE(4)) u_b (
        .SC_UPDOWNCOUNTER_CLOCK_50    (clk),
        .SC_UPDOWNCOUNTER_RESET_InLow (rst_n),
        .cnt_if                       (if_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_ph[i]  = 0;
            m_wr[i]  = 0;
        end
    endtask

    // Behaviour of one clock edge, written as modular arithmetic on integers.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_wr[i] = 0;
            if (clr) begin
                m_cnt[i] = 0;
                m_ph[i]  = 0;
            end else if (ld) begin
                m_cnt[i] = (int'(ldv) > MAXV[i]) ? MAXV[i] : int'(ldv);
                m_ph[i]  = 0;
            end else if (!en_n) begin
                if (m_ph[i] == PRE[i] - 1) begin
                    m_ph[i] = 0;
                    if (dn == DIR_DOWN) begin
                        m_wr[i]  = (m_cnt[i] == 0) ? 1 : 0;
                        m_cnt[i] = (m_cnt[i] + MAXV[i]) % (MAXV[i] + 1);
                    end else begin
                        m_wr[i]  = (m_cnt[i] == MAXV[i]) ? 1 : 0;
                        m_cnt[i] = (m_cnt[i] + 1) % (MAXV[i] + 1);
                    end
                end else begin
                    m_ph[i] = m_ph[i] + 1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/a.data"}, int'(if_a.SC_UPDOWNCOUNTER_data_OutBUS), m_cnt[0]);
        chk({tag, "/a.wrap"}, int'(if_a.SC_UPDOWNCOUNTER_wrap_OutHigh), m_wr[0]);
        chk({tag, "/a.zero"}, int'(if_a.SC_UPDOWNCOUNTER_zero_OutHigh), (m_cnt[0] == 0) ? 1 : 0);
        chk({tag, "/a.max"},  int'(if_a.SC_UPDOWNCOUNTER_max_OutHigh),  (m_cnt[0] == MAXV[0]) ? 1 : 0);
        chk({tag, "/b.data"}, int'(if_b.SC_UPDOWNCOUNTER_data_OutBUS), m_cnt[1]);
        chk({tag, "/b.wrap"}, int'(if_b.SC_UPDOWNCOUNTER_wrap_OutHigh), m_wr[1]);
        chk({tag, "/b.zero"}, int'(if_b.SC_UPDOWNCOUNTER_zero_OutHigh), (m_cnt[1] == 0) ? 1 : 0);
        chk({tag, "/b.max"},  int'(if_b.SC_UPDOWNCOUNTER_max_OutHigh),  (m_cnt[1] == MAXV[1]) ? 1 : 0);
    endtask

    task automatic set_in(input logic c, input logic l, input int lv,
                          input logic e_n, input logic d);
        clr  = c;
        ld   = l;
        ldv  = DW'(lv);
        en_n = e_n;
        dn   = d;
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cycle(input string tag, input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all(tag);
        end
    endtask

    // Async reset asserted between edges, released on the next falling edge.
    task automatic mid_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 1, DIR_UP);
        model_reset();
        #2;
        check_all("t1_reset");
        chk("t1_reset_zero", int'(if_a.SC_UPDOWNCOUNTER_zero_OutHigh), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: count up from reset with PRESCALE=1.
        set_in(0, 0, 0, 0, DIR_UP);
        cycle("t1_up", 3);
        chk("t1_count3", int'(if_a.SC_UPDOWNCOUNTER_data_OutBUS), 3);

        // 2: up wrap at 9.
        set_in(1, 0, 0, 0, DIR_UP);
        cycle("t2_clr");
        set_in(0, 0, 0, 0, DIR_UP);
        cycle("t2_up", 9);
        chk("t2_max_at9", int'(if_a.SC_UPDOWNCOUNTER_max_OutHigh), 1);
        cycle("t2_wrap");
        chk("t2_wrap_pulse", int'(if_a.SC_UPDOWNCOUNTER_wrap_OutHigh), 1);
        cycle("t2_after");
        chk("t2_wrap_gone", int'(if_a.SC_UPDOWNCOUNTER_wrap_OutHigh), 0);

        // 3: down wrap from 1.
        set_in(0, 1, 1, 0, DIR_DOWN);
        cycle("t3_load1");
        set_in(0, 0, 0, 0, DIR_DOWN);
        cycle("t3_down");
        chk("t3_zero_at0", int'(if_a.SC_UPDOWNCOUNTER_zero_OutHigh), 1);
        cycle("t3_wrap");
        chk("t3_data9", int'(if_a.SC_UPDOWNCOUNTER_data_OutBUS), 9);
        chk("t3_wrap_pulse", int'(if_a.SC_UPDOWNCOUNTER_wrap_OutHigh), 1);

        // 4: prescaler of 4 with a freeze mid-phase.
        set_in(1, 0, 0, 0, DIR_UP);
        cycle("t4_clr");
        set_in(0, 0, 0, 0, DIR_UP);
        cycle("t4_run", 12);
        chk("t4_three_steps", int'(if_b.SC_UPDOWNCOUNTER_data_OutBUS), 3);
        cycle("t4_phase", 2);
        set_in(0, 0, 0, 1, DIR_UP);
        cycle("t4_frozen", 5);
        chk("t4_frozen_data", int'(if_b.SC_UPDOWNCOUNTER_data_OutBUS), 3);
        set_in(0, 0, 0, 0, DIR_UP);
        cycle("t4_resume", 2);
        chk("t4_resumed", int'(if_b.SC_UPDOWNCOUNTER_data_OutBUS), 4);

        // 5: load clamp, clear beats load, load beats a wrapping tick.
        set_in(0, 1, 200, 0, DIR_UP);
        cycle("t5_clamp");
        chk("t5_clamp150", int'(if_b.SC_UPDOWNCOUNTER_data_OutBUS), 150);
        set_in(1, 1, 77, 0, DIR_UP);
        cycle("t5_clr_ld");
        chk("t5_clr_wins", int'(if_b.SC_UPDOWNCOUNTER_data_OutBUS), 0);
        set_in(0, 1, 9, 0, DIR_UP);
        cycle("t5_ld9");
        set_in(0, 1, 4, 0, DIR_UP);
        cycle("t5_ld_vs_wrap");
        chk("t5_ld_data", int'(if_a.SC_UPDOWNCOUNTER_data_OutBUS), 4);
        chk("t5_ld_nowrap", int'(if_a.SC_UPDOWNCOUNTER_wrap_OutHigh), 0);

        // 6: async reset mid-count (b at 7, phase 2).
        set_in(1, 0, 0, 0, DIR_UP);
        cycle("t6_clr");
        set_in(0, 0, 0, 0, DIR_UP);
        cycle("t6_run", 30);
        chk("t6_at7", int'(if_b.SC_UPDOWNCOUNTER_data_OutBUS), 7);
        mid_reset("t6_reset");
        chk("t6_reset_data", int'(if_b.SC_UPDOWNCOUNTER_data_OutBUS), 0);
        cycle("t6_post", 3);
        chk("t6_no_early_step", int'(if_b.SC_UPDOWNCOUNTER_data_OutBUS), 0);
        cycle("t6_first");
        chk("t6_first_step", int'(if_b.SC_UPDOWNCOUNTER_data_OutBUS), 1);

        // Randomized traffic.
        for (int it = 0; it < 3000; it++) begin
            set_in(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                   ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                   int'($urandom_range(0, 255)),
                   ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                   ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0);
            cycle("rand");
            if ($urandom_range(0, 199) == 0) mid_reset("rand_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
